phase_center_loader: RTL
========================

# phase_center_loader

Sequencer between the software-written `load_centers` and `center_data` registers and the phase-center RAM of the phase-conversion block. It turns rising edges on software request bits into timed RAM write strobes. All loads go to a shadow bank; a commit swaps the active bank only at a datapath frame boundary. This gives the datapath a glitch-free, atomic center update across all channels. It runs in the `user_clk` domain, after the OPB-to-fabric register bridge and before the dual-bank center RAM.

## Interface
Parameters:
- `N_CH`, 256, number of channels (power of two)
- `ADDR_W`, 8, log2(N_CH)
- `CTR_W`, 16, phase-center word width

Ports:
- `user_clk`  in  1  sole clock
- `user_rst_n`  in  1  asynchronous active-low reset
- `load_centers`  in  32  software request word:
  - [0] write request (rising edge)
  - [1] clear-all request (rising edge)
  - [2] commit request (rising edge)
  - [ADDR_W+2:3] channel address
  - remaining bits ignored
- `center_data`  in  32  [CTR_W-1:0] center value; upper bits ignored
- `frame_sync`  in  1  one-cycle pulse when the datapath channel counter wraps to 0
- `mem_we`  out  1  center RAM write enable
- `mem_waddr`  out  ADDR_W+1  {bank, channel}; bank bit is always the inactive bank
- `mem_wdata`  out  CTR_W  RAM write data
- `bank_sel`  out  1  active bank, read by the datapath
- `status`  out  32  [15:0] write_cnt, [23:16] drop_cnt, [29:24] 0, [30] bank_sel, [31] busy

## Operation
- Input stage: `load_centers[2:0]` is registered into `d1`, then into `d2`. Edge = `d1 & ~d2`.
  - Address and data are captured from the `d1`-stage copies of `load_centers` and `center_data` in the edge cycle.
- FSM states: IDLE, WR, CLR, SWAP_WAIT.
  - IDLE, clear edge → CLR; clear counter = 0.
  - IDLE, else write edge → WR; address and data latched.
  - IDLE, else commit edge → SWAP_WAIT.
  - Simultaneous edges resolve by priority clear > write > commit. Each losing edge increments `drop_cnt`.
  - WR: lasts one cycle; `mem_we`=1, `mem_waddr`={~bank_sel, addr}, `mem_wdata`=data. Then `write_cnt`+1 (wrapping) and → IDLE.
  - CLR: lasts N_CH cycles; `mem_we`=1, `mem_wdata`=0, channel = counter 0..N_CH-1. After the channel N_CH-1 write → IDLE.
  - SWAP_WAIT: no writes. On the first cycle `frame_sync`=1 is sampled, `bank_sel` toggles → IDLE.
- Any request edge detected outside IDLE is dropped and increments `drop_cnt`. Loss of two edges in one cycle counts +2.
- `drop_cnt` saturates at 255. `write_cnt` wraps at 2^16. CLR does not increment `write_cnt`.
- `frame_sync` outside SWAP_WAIT is ignored.
- `busy` = (state != IDLE).
- Writes never target the active bank, so no read/write collision handling is needed.

## Timing
- Reset values (asynchronous, active-low):
  - state IDLE; `d1`, `d2` = 0
  - `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0
  - `bank_sel`=0, `write_cnt`=0, `drop_cnt`=0, `status`=0
- Request bits held high through reset release produce one edge after release.
- Latency, with request bit first sampled high at edge k:
  - `d1` high after k; edge detected in cycle k..k+1; FSM enters WR/CLR/SWAP_WAIT at edge k+1.
  - `mem_we` is high during cycle k+1..k+2.
- Outputs are registered with the state; `mem_*` change only at clock edges.
- Single write: exactly 1 `mem_we` cycle; `busy` high for 1 cycle.
- Clear: `mem_we` high for exactly N_CH consecutive cycles; `busy` high for N_CH cycles.
- Commit: `bank_sel` toggles at the edge sampling `frame_sync`=1. `busy` falls the same edge.
- Reset asserted mid-CLR or mid-SWAP_WAIT aborts immediately:
  - `mem_we`=0, `bank_sel`=0.
  - No partial sweep resumes after release.
- Throughput: back-to-back write requests need the bit low ≥1 cycle between rising edges. Minimum spacing is 2 cycles; an edge arriving in the WR cycle is dropped.

## Test plan
- Reset, then write addr=5, data=0x1234 → one `mem_we` pulse 2 cycles after the request; `mem_waddr`=0x105; `mem_wdata`=0x1234; `write_cnt`=1; `bank_sel`=0.
- Clear request → `mem_we` high for 256 cycles; `mem_waddr` 0x100..0x1FF; `mem_wdata`=0; `busy` then low; `write_cnt` unchanged.
- Commit, with `frame_sync` pulsed 40 cycles later → `busy` high 40+ cycles; `bank_sel` 0→1 on the `frame_sync` edge.
- Then write addr=7 → `mem_waddr`=0x007.
- Write edge during CLR, plus a simultaneous write+commit in IDLE → `drop_cnt`=2; only the write executes.
- 300 dropped requests → `drop_cnt` saturates at 255.
- Assert `user_rst_n`=0 at CLR cycle 100 → `mem_we` falls immediately; all status fields 0; `bank_sel`=0.

Source files
------------

// File: rtl/phase_center_loader.sv
// Sequencer turning software request edges into phase-center RAM write strobes.
// All writes target the shadow bank; commits swap banks only on a frame boundary.
module phase_center_loader #(
    parameter int N_CH   = 256,
    parameter int ADDR_W = 8,
    parameter int CTR_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       load_centers,
    input  logic [31:0]       center_data,
    input  logic              frame_sync,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [CTR_W-1:0]  mem_wdata,
    output logic              bank_sel,
    output logic [31:0]       status
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WR        = 2'd1;
    localparam logic [1:0] S_CLR       = 2'd2;
    localparam logic [1:0] S_SWAP_WAIT = 2'd3;

    logic [2:0]        d1;
    logic [2:0]        d2;
    logic [ADDR_W-1:0] addr_d1;
    logic [CTR_W-1:0]  data_d1;
    logic [2:0]        req_edge;
    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [15:0]       write_cnt;
    logic [7:0]        drop_cnt;
    logic [1:0]        n_edges;
    logic [1:0]        n_lost;
    logic [8:0]        drop_sum;
    logic              busy;
    logic              unused_bits;

    assign unused_bits = ^{load_centers[31:ADDR_W+3], center_data[31:CTR_W]};

    // Address and data follow the request bits through the same first stage so
    // they are captured coherently with the detected edge.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            d1      <= '0;
            d2      <= '0;
            addr_d1 <= '0;
            data_d1 <= '0;
        end else begin
            d1      <= load_centers[2:0];
            d2      <= d1;
            addr_d1 <= load_centers[ADDR_W+2:3];
            data_d1 <= center_data[CTR_W-1:0];
        end
    end

    // In IDLE one edge wins and the rest are lost; elsewhere every edge is lost.
    always_comb begin
        req_edge = d1 & ~d2;
        n_edges  = {1'b0, req_edge[0]} + {1'b0, req_edge[1]} + {1'b0, req_edge[2]};
        if (state == S_IDLE && n_edges != 2'd0)
            n_lost = n_edges - 2'd1;
        else
            n_lost = n_edges;
        drop_sum = {1'b0, drop_cnt} + {7'd0, n_lost};
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            bank_sel  <= 1'b0;
            write_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            case (state)
                S_IDLE: begin
                    if (req_edge[1]) begin
                        state     <= S_CLR;
                        clr_cnt   <= '0;
                        mem_we    <= 1'b1;
                        mem_waddr <= {~bank_sel, {ADDR_W{1'b0}}};
                        mem_wdata <= '0;
                    end else if (req_edge[0]) begin
                        state     <= S_WR;
                        mem_we    <= 1'b1;
                        mem_waddr <= {~bank_sel, addr_d1};
                        mem_wdata <= data_d1;
                    end else if (req_edge[2]) begin
                        state <= S_SWAP_WAIT;
                    end
                end
                S_WR: begin
                    mem_we    <= 1'b0;
                    write_cnt <= write_cnt + 16'd1;
                    state     <= S_IDLE;
                end
                S_CLR: begin
                    if (clr_cnt == ADDR_W'(N_CH - 1)) begin
                        mem_we <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        clr_cnt   <= clr_cnt + ADDR_W'(1);
                        mem_waddr <= {~bank_sel, clr_cnt + ADDR_W'(1)};
                    end
                end
                S_SWAP_WAIT: begin
                    if (frame_sync) begin
                        bank_sel <= ~bank_sel;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign status = {busy, bank_sel, 6'd0, drop_cnt, write_cnt};

endmodule
